led_tube_scanner: RTL
=====================

Name: led_tube_scanner

Overview:
- Parametrised multiplexed seven-segment display scanner. Successor to the fixed 8-digit LED tube driver.
- Adds: configurable digit count, full hex decode, per-digit decimal point and blanking, anti-ghosting dead time, PWM brightness, output polarity selection, and double-buffered frame-synchronous updates.
- Sits between the CPU/MMIO debug registers and the board LED tube pins.

Parameters:
- NUM_DIGITS, 8, number of tubes scanned (1..16).
- DIGIT_CYCLES, 8192, clk cycles per digit slot (>= DEAD_CYCLES+2^BRIGHT_W).
- DEAD_CYCLES, 64, cycles at the start of each slot with all tubes off (>= 1).
- BRIGHT_W, 4, brightness input width.
- SEG_ACTIVE_LOW, 1, 1: segment lit = 0.
- EN_ACTIVE_LOW, 1, 1: tube enabled = 0.

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit i = [4i+3:4i]; digit 0 is the rightmost tube
- dots_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_in  in  NUM_DIGITS  1 = digit dark
- load  in  1  single-cycle strobe that captures digits_in, dots_in and blank_in
- brightness  in  BRIGHT_W  0 = dimmest, all-ones = full
- update_pending  out  1  captured data not yet displayed
- frame_pulse  out  1  one-cycle pulse on the last cycle of each full scan
- en  out  NUM_DIGITS  tube enables, en[i] drives digit i
- dataout  out  8  segments: [7]=dp, [6]=g(center), [5]=f(left top), [4]=e(left bottom), [3]=d(bottom), [2]=c(right bottom), [1]=b(right top), [0]=a(top)

Behaviour:
- Reset (async assert, sync release):
  - slot_cnt=0, digit_idx=0, state=DEAD.
  - Active and pending buffers: blank mask all-ones, digits and dots 0. update_pending=0.
  - en all inactive, dataout all-off (polarity-corrected), frame_pulse=0.
- Slot counter slot_cnt runs 0..DIGIT_CYCLES-1, then wraps to 0.
  - On wrap, digit_idx increments; it wraps from NUM_DIGITS-1 to 0.
  - Frame boundary = the cycle where slot_cnt=DIGIT_CYCLES-1 and digit_idx=NUM_DIGITS-1. frame_pulse=1 on exactly that cycle.
- Lit length: brightness is sampled when slot_cnt=0 and held for the slot. lit_len = ((DIGIT_CYCLES-DEAD_CYCLES) >> BRIGHT_W) * (brightness+1).
- FSM per slot:
  - DEAD: slot_cnt < DEAD_CYCLES. Moves to LIT at slot_cnt=DEAD_CYCLES.
  - LIT: slot_cnt < DEAD_CYCLES+lit_len. Moves to DARK when that bound is reached.
  - DARK: lasts to the end of the slot, then returns to DEAD.
  - LIT only occurs if the digit is not blanked. A blanked digit goes DEAD to DARK.
- Outputs are registered, one cycle after the FSM state:
  - In LIT: en[digit_idx] active, all other enables inactive, dataout = decode(active digit) with dp = dot.
  - In DEAD and DARK: all enables inactive, dataout all-off.
- Hex decode, active-low form, g..a in [6:0], dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - dp lit clears bit7.
  - SEG_ACTIVE_LOW=0 inverts all 8 bits. EN_ACTIVE_LOW=0 inverts en.
- Double buffering:
  - load copies inputs into the pending buffer and sets update_pending.
  - At the frame boundary, if update_pending=1, pending is copied to active and update_pending is cleared.
  - Repeated loads before the boundary: the last one wins.
  - load on the frame-boundary cycle: inputs go straight to active, pending is not used, update_pending=0 next cycle.
  - Active data never changes mid-frame.
- brightness changes take effect at the next slot start only. The current slot keeps its lit_len.
- Reset mid-LIT: en and dataout go inactive immediately (async); scanning restarts at digit 0.

Decomposition:
- Shared package led_tube_pkg holds:
  - segment bit-index constants (SEG_DP..SEG_A);
  - the 16-entry hex decode constant table;
  - the FSM state enum (DEAD, LIT, DARK).
- One sub-module, seg7_hex_decode: combinational, nibble+dot to 8-bit active-low segments. Polarity is applied in the top module.

Test Plan (NUM_DIGITS=4, DIGIT_CYCLES=32, DEAD_CYCLES=4, BRIGHT_W=2, so lit_len = 7*(b+1)):
- Reset, then load digits=0x3210, dots=0, blank=0, brightness=3 -> en stays 4'b1111 and dataout=FF until the first frame boundary (cycle 127). In the next frame's slot 0, en=1110 for 28 cycles after 4 dead cycles, dataout=C0. Slots 1..3 show F9, A4, B0 with en 1101, 1011, 0111.
- brightness=0 -> each slot: 4 cycles off, 7 cycles lit, 21 cycles off. brightness changed mid-slot -> the current slot's lit length is unchanged.
- digits=0xFEDC, dots=4'b0101 -> slot outputs 46 (C with dp), A1, 06 (E with dp), 8E.
- blank=4'b0010 -> en[1] never asserts and dataout stays FF through slot 1; the other slots are unaffected.
- Mid-frame: load 0x1111 then load 0x2222 -> display unchanged and update_pending=1 until the boundary. Then 0x2222 is shown and update_pending=0. load on the frame_pulse cycle -> new data shown in the next frame and update_pending stays 0.
- Deassert reset_n during a LIT cycle -> en=1111 and dataout=FF in the same cycle, without a clk edge. After release, the scan restarts at digit 0, slot_cnt 0, with all digits blank.

Source files
------------

// File: rtl/led_tube_pkg.sv
// led_tube_pkg: shared segment bit positions, hex glyph table and scan states
package led_tube_pkg;
    localparam int SEG_DP = 7;
    localparam int SEG_G = 6;
    localparam int SEG_F = 5;
    localparam int SEG_E = 4;
    localparam int SEG_D = 3;
    localparam int SEG_C = 2;
    localparam int SEG_B = 1;
    localparam int SEG_A = 0;
    // Active-low glyphs with dp off; entry n is the glyph for nibble n
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };
    typedef enum logic [1:0] {DEAD, LIT, DARK} scan_state_t;
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble plus decimal point to active-low segment pattern
module seg7_hex_decode
    import led_tube_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dot,
    output logic [7:0] seg
);
    always_comb begin
        seg = HEX_SEG[nibble];
        seg[SEG_DP] = ~dot;
    end
endmodule

// File: rtl/led_tube_scanner.sv
// led_tube_scanner: multiplexed seven-segment scanner with dead time, PWM
// brightness, polarity selection and frame-synchronous double buffering
module led_tube_scanner
    import led_tube_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int DIGIT_CYCLES   = 8192,
    parameter int DEAD_CYCLES    = 64,
    parameter int BRIGHT_W       = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dots_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      load,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic                      update_pending,
    output logic                      frame_pulse,
    output logic [NUM_DIGITS-1:0]     en,
    output logic [7:0]                dataout
);
    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned UNIT = (DIGIT_CYCLES - DEAD_CYCLES) >> BRIGHT_W;
    localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{EN_ACTIVE_LOW != 0}};
    localparam logic [7:0] SEG_INV = {8{SEG_ACTIVE_LOW == 0}};

    logic [CW-1:0]           slot_cnt;
    logic [DW-1:0]           digit_idx;
    scan_state_t             state;
    logic [BRIGHT_W-1:0]     bright_q;
    logic [4*NUM_DIGITS-1:0] dig_act, dig_pend;
    logic [NUM_DIGITS-1:0]   dot_act, dot_pend, blank_act, blank_pend, sel;
    logic [31:0]             cnt32, lit_end;
    logic                    last_slot, last_digit;
    logic [3:0]              nib;
    logic [7:0]              seg;

    assign cnt32       = 32'(slot_cnt);
    assign last_slot   = cnt32 == DIGIT_CYCLES - 1;
    assign last_digit  = 32'(digit_idx) == NUM_DIGITS - 1;
    assign frame_pulse = last_slot && last_digit;
    // On slot_cnt 0 the register has not captured yet, so use the live input
    assign lit_end = DEAD_CYCLES + UNIT * (32'(slot_cnt == '0 ? brightness : bright_q) + 1);
    assign nib     = dig_act[4*digit_idx +: 4];
    assign sel     = NUM_DIGITS'(1) << digit_idx;

    seg7_hex_decode u_dec (
        .nibble(nib),
        .dot   (dot_act[digit_idx]),
        .seg   (seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            state     <= DEAD;
            bright_q  <= '0;
        end else begin
            slot_cnt <= last_slot ? '0 : slot_cnt + 1'b1;
            if (last_slot) digit_idx <= last_digit ? '0 : digit_idx + 1'b1;
            if (slot_cnt == '0) bright_q <= brightness;
            if (last_slot) state <= DEAD;
            else case (state)
                DEAD:    if (cnt32 == DEAD_CYCLES - 1) state <= blank_act[digit_idx] ? DARK : LIT;
                LIT:     if (cnt32 == lit_end - 1) state <= DARK;
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_act        <= '0;
            dot_act        <= '0;
            blank_act      <= '1;
            dig_pend       <= '0;
            dot_pend       <= '0;
            blank_pend     <= '1;
            update_pending <= 1'b0;
        end else begin
            // A load on the boundary bypasses the pending buffer entirely
            if (load && frame_pulse) begin
                dig_act   <= digits_in;
                dot_act   <= dots_in;
                blank_act <= blank_in;
            end else begin
                if (frame_pulse && update_pending) begin
                    dig_act   <= dig_pend;
                    dot_act   <= dot_pend;
                    blank_act <= blank_pend;
                end
                if (load) begin
                    dig_pend   <= digits_in;
                    dot_pend   <= dots_in;
                    blank_pend <= blank_in;
                end
            end
            update_pending <= (load || update_pending) && !frame_pulse;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en      <= EN_OFF;
            dataout <= ~SEG_INV;
        end else begin
            en      <= state == LIT ? EN_OFF ^ sel : EN_OFF;
            dataout <= state == LIT ? seg ^ SEG_INV : ~SEG_INV;
        end
    end
endmodule
